// File: rtl/mt_rand_stream.sv
// -----------------------------------------------------------------------------
// mt_rand_stream
//   Consumer side of the Mersenne-twister generator. Keeps extraction requests
//   flowing to the generator while buffer space exists, captures each returned
//   32-bit word into a small FIFO, and re-presents the words as a valid/ready
//   stream of OUT_W-bit slices (least-significant slice first). Periods where
//   the generator ignores requests are absorbed by the buffer.
//
//   Ports
//     clk        clock, all state on the rising edge
//     rst        asynchronous active-high reset
//     gen_trig   extraction request, one word per asserted cycle
//     gen_ready  generator response pulse (cycle after an accepted request)
//     gen_num    generator word, valid while gen_ready=1
//     flush      synchronous discard of all buffered data
//     out_valid  out_data holds a slice
//     out_ready  consumer accepts the current slice
//     out_data   current slice
//     level      words held in the FIFO (unpacker word not included)
//     ovf_err    sticky: response with no space or with no request outstanding
// -----------------------------------------------------------------------------
module mt_rand_stream #(
    parameter int DEPTH = 4,
    parameter int OUT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     gen_trig,
    input  logic                     gen_ready,
    input  logic [31:0]              gen_num,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int K  = 32 / OUT_W;
    localparam int SW = (K > 1) ? $clog2(K) : 1;
    localparam logic [SW-1:0] LAST_SIDX = SW'(K - 1);

    // FIFO storage; the unpacker word register acts as its registered read port
    logic [31:0]    mem_q [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           trig_q;
    logic           discard_q;
    logic           ovf_q, ovf_d;
    logic [31:0]    word_q, word_d;
    logic [SW-1:0]  sidx_q, sidx_d;
    logic           uvalid_q, uvalid_d;

    logic           full;
    logic [LW:0]    credit_sum;
    logic           resp_ok;
    logic           push;
    logic           pop;
    logic           xfer;
    logic           last_slice;
    logic [5:0]     shamt;

    assign full       = (cnt_q == LW'(DEPTH));
    // Words already buffered plus the one possibly in flight must fit
    assign credit_sum = {1'b0, cnt_q} + {{LW{1'b0}}, trig_q};
    assign gen_trig   = !rst && !flush && (credit_sum < (LW + 1)'(DEPTH));

    // A response in the flush cycle or the cycle after (discard) belongs to
    // data being thrown away, so it is neither stored nor flagged.
    assign resp_ok    = gen_ready && !flush && !discard_q;
    assign push       = resp_ok && trig_q && !full;

    assign xfer       = uvalid_q && out_ready;
    assign last_slice = (sidx_q == LAST_SIDX);
    // Load the FIFO head into an empty unpacker, or straight behind the last
    // slice so back-to-back words stream without a bubble.
    assign pop        = (cnt_q != '0) && (!uvalid_q || (xfer && last_slice));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        sidx_d   = sidx_q;
        uvalid_d = uvalid_q;
        ovf_d    = ovf_q | (resp_ok && (!trig_q || full));

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (xfer) begin
            if (last_slice) begin
                sidx_d   = '0;
                uvalid_d = 1'b0;
            end else begin
                sidx_d = sidx_q + SW'(1);
            end
        end
        if (pop) begin
            word_d   = mem_q[rd_ptr_q];
            sidx_d   = '0;
            uvalid_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            word_d   = '0;
            sidx_d   = '0;
            uvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= gen_num;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            discard_q <= 1'b0;
            ovf_q     <= 1'b0;
            word_q    <= '0;
            sidx_q    <= '0;
            uvalid_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            trig_q    <= gen_trig;
            // A request outstanding at flush time will answer next cycle
            discard_q <= flush && trig_q;
            ovf_q     <= ovf_d;
            word_q    <= word_d;
            sidx_q    <= sidx_d;
            uvalid_q  <= uvalid_d;
        end
    end

    assign shamt     = 6'(sidx_q) * 6'(OUT_W);
    assign out_data  = OUT_W'(word_q >> shamt);
    assign out_valid = uvalid_q;
    assign level     = cnt_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mt_rand_stream.sv
module tb_mt_rand_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance A: 32-bit slices, driven by a stub generator
    logic        a_gen_trig;
    logic        a_gen_ready = 1'b0;
    logic [31:0] a_gen_num = '0;
    logic        a_flush = 1'b0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_out_data;
    logic [2:0]  a_level;
    logic        a_ovf_err;

    // Instance B: 8-bit slices, driven by hand
    logic        b_gen_trig;
    logic        b_gen_ready = 1'b0;
    logic [31:0] b_gen_num = '0;
    logic        b_flush = 1'b0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_out_data;
    logic [2:0]  b_level;
    logic        b_ovf_err;

    mt_rand_stream #(.DEPTH(4), .OUT_W(32)) u_a (
        .clk(clk), .rst(rst), .gen_trig(a_gen_trig), .gen_ready(a_gen_ready),
        .gen_num(a_gen_num), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .level(a_level),
        .ovf_err(a_ovf_err)
    );

    mt_rand_stream #(.DEPTH(4), .OUT_W(8)) u_b (
        .clk(clk), .rst(rst), .gen_trig(b_gen_trig), .gen_ready(b_gen_ready),
        .gen_num(b_gen_num), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .level(b_level),
        .ovf_err(b_ovf_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        stub_en = 1'b1;
    logic        stub_busy = 1'b0;
    logic [31:0] stub_val = 32'd1;
    logic [31:0] exp_next = 32'd1;
    int          xfer_cnt = 0;
    logic        trig_seen;
    logic        found;

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] data;
        logic [2:0]  lvl;
        logic        trig;
    } fill_vec_t;

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        rdy;
    } slice_vec_t;

    fill_vec_t  fill_tbl [13];
    slice_vec_t slice_tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: sample before the edge, answer as the stub after it
    task automatic tick();
        #1;
        trig_seen = a_gen_trig;
        if (a_out_valid && a_out_ready) begin
            $display("xfer A word %h", a_out_data);
            chk("stream_order", a_out_data, exp_next);
            exp_next = exp_next + 32'd1;
            xfer_cnt++;
        end
        @(posedge clk);
        #1;
        if (stub_en) begin
            if (!stub_busy && trig_seen) begin
                a_gen_ready = 1'b1;
                a_gen_num   = stub_val;
                stub_val    = stub_val + 32'd1;
            end else begin
                a_gen_ready = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        fill_tbl[0]  = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b1};
        fill_tbl[1]  = '{1'b0, 1'b0, 32'd0, 3'd1, 1'b1};
        fill_tbl[2]  = '{1'b0, 1'b1, 32'd1, 3'd1, 1'b1};
        fill_tbl[3]  = '{1'b0, 1'b1, 32'd1, 3'd2, 1'b1};
        fill_tbl[4]  = '{1'b0, 1'b1, 32'd1, 3'd3, 1'b0};
        fill_tbl[5]  = '{1'b0, 1'b1, 32'd1, 3'd4, 1'b0};
        fill_tbl[6]  = '{1'b0, 1'b1, 32'd1, 3'd4, 1'b0};
        fill_tbl[7]  = '{1'b1, 1'b1, 32'd2, 3'd3, 1'b1};
        fill_tbl[8]  = '{1'b1, 1'b1, 32'd3, 3'd2, 1'b1};
        fill_tbl[9]  = '{1'b1, 1'b1, 32'd4, 3'd2, 1'b1};
        fill_tbl[10] = '{1'b1, 1'b1, 32'd5, 3'd2, 1'b1};
        fill_tbl[11] = '{1'b1, 1'b1, 32'd6, 3'd2, 1'b1};
        fill_tbl[12] = '{1'b1, 1'b1, 32'd7, 3'd2, 1'b1};

        slice_tbl[0]  = '{1'b1, 8'hD4, 1'b1};
        slice_tbl[1]  = '{1'b1, 8'hC3, 1'b0};
        slice_tbl[2]  = '{1'b1, 8'hC3, 1'b1};
        slice_tbl[3]  = '{1'b1, 8'hB2, 1'b1};
        slice_tbl[4]  = '{1'b1, 8'hA1, 1'b0};
        slice_tbl[5]  = '{1'b1, 8'hA1, 1'b1};
        slice_tbl[6]  = '{1'b1, 8'h44, 1'b1};
        slice_tbl[7]  = '{1'b1, 8'h33, 1'b1};
        slice_tbl[8]  = '{1'b1, 8'h22, 1'b1};
        slice_tbl[9]  = '{1'b1, 8'h11, 1'b1};
        slice_tbl[10] = '{1'b0, 8'h00, 1'b0};

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_trig",  a_gen_trig,  0);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_level", a_level,     0);
        chk("rst_a_data",  a_out_data,  0);
        chk("rst_a_ovf",   a_ovf_err,   0);
        chk("rst_b_trig",  b_gen_trig,  0);
        chk("rst_b_valid", b_out_valid, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_trig", a_gen_trig, 1);

        // ---------------- basic fill then drain ----------------
        for (int i = 0; i < 13; i++) begin
            a_out_ready = fill_tbl[i].rdy;
            tick();
            $display("fill row %0d: valid=%0b data=%h level=%0d trig=%0b",
                     i, a_out_valid, a_out_data, a_level, a_gen_trig);
            chk("fill_valid", a_out_valid, fill_tbl[i].vld);
            chk("fill_data",  a_out_data,  fill_tbl[i].data);
            chk("fill_level", a_level,     fill_tbl[i].lvl);
            chk("fill_trig",  a_gen_trig,  fill_tbl[i].trig);
            chk("fill_ovf",   a_ovf_err,   0);
        end

        // ---------------- slicing on the 8-bit instance ----------------
        b_gen_ready = 1'b1;
        b_gen_num   = 32'hA1B2C3D4;
        tick();
        b_gen_num   = 32'h11223344;
        tick();
        b_gen_ready = 1'b0;
        chk("slice_level", b_level, 1);
        for (int i = 0; i < 11; i++) begin
            $display("slice row %0d: valid=%0b data=%h", i, b_out_valid, b_out_data);
            chk("slice_valid", b_out_valid, slice_tbl[i].vld);
            if (slice_tbl[i].vld) begin
                chk("slice_data", b_out_data, slice_tbl[i].data);
            end
            b_out_ready = slice_tbl[i].rdy;
            tick();
        end
        chk("slice_level_end", b_level, 0);
        chk("slice_ovf", b_ovf_err, 0);

        // ---------------- busy generator ----------------
        stub_busy = 1'b1;
        repeat (20) tick();
        chk("busy_valid", a_out_valid, 0);
        chk("busy_level", a_level, 0);
        chk("busy_ovf",   a_ovf_err, 0);
        stub_busy = 1'b0;
        xfer_cnt  = 0;
        repeat (20) tick();
        chk("busy_resume_xfers", xfer_cnt, 17);

        // ---------------- flush with request in flight ----------------
        a_out_ready = 1'b0;
        repeat (8) tick();
        chk("pre_flush_level", a_level, 4);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        stub_en     = 1'b0;
        a_gen_ready = 1'b0;
        tick();
        a_flush = 1'b1;
        #1;
        chk("flush_trig", a_gen_trig, 0);
        tick();
        a_flush     = 1'b0;
        a_gen_ready = 1'b1;
        a_gen_num   = 32'h00000055;
        tick();
        a_gen_ready = 1'b0;
        chk("flush_level", a_level, 0);
        chk("flush_valid", a_out_valid, 0);
        chk("flush_ovf",   a_ovf_err, 0);
        exp_next    = stub_val;
        stub_en     = 1'b1;
        a_out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (a_out_valid) found = 1'b1;
            else tick();
        end
        chk("flush_resume_seen", found, 1);
        chk("flush_resume_data", a_out_data, exp_next);

        // ---------------- protocol error ----------------
        a_out_ready = 1'b0;
        repeat (8) tick();
        chk("perr_pre_level", a_level, 4);
        stub_en     = 1'b0;
        a_gen_ready = 1'b1;
        a_gen_num   = 32'hDEADBEEF;
        tick();
        a_gen_ready = 1'b0;
        chk("perr_ovf",   a_ovf_err, 1);
        chk("perr_level", a_level, 4);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("perr_flush_ovf",   a_ovf_err, 1);
        chk("perr_flush_level", a_level, 0);
        tick();
        chk("perr_sticky_ovf", a_ovf_err, 1);

        // ---------------- asynchronous reset mid-stream ----------------
        exp_next    = stub_val;
        stub_en     = 1'b1;
        a_out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (a_out_valid) found = 1'b1;
            else tick();
        end
        chk("arst_pre_valid", found, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", a_out_valid, 0);
        chk("arst_trig",  a_gen_trig,  0);
        chk("arst_level", a_level,     0);
        chk("arst_data",  a_out_data,  0);
        chk("arst_ovf",   a_ovf_err,   0);
        #20;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mt_rand_stream.md
# mt_rand_stream

Downstream consumer of the Mersenne-twister generator: issues extraction requests (`trig`) to the generator, captures each 32-bit output word on the generator's `ready` pulse, buffers words in a small FIFO, and presents them to the rest of the design as a valid/ready stream. Each word can be split into `OUT_W`-bit slices. The block hides the generator's unavailable periods (initialisation and regeneration phases, when requests are silently ignored) behind the buffer.

## Interface
- `DEPTH`, 4: FIFO depth in 32-bit words; power of 2, ≥2.
- `OUT_W`, 32: output slice width; one of 8, 16, 32. `K = 32/OUT_W` slices per word.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `gen_trig`  out  1  extraction request to the generator, one word per asserted cycle.
- `gen_ready`  in  1  generator response pulse; arrives the cycle after an accepted `gen_trig`, or never if the generator was busy.
- `gen_num`  in  32  generator word, valid only while `gen_ready`=1.
- `flush`  in  1  synchronous discard of all buffered data.
- `out_valid`  out  1  `out_data` holds a slice.
- `out_ready`  in  1  consumer accepts a slice.
- `out_data`  out  OUT_W  current slice.
- `level`  out  clog2(DEPTH)+1  words in FIFO, excluding the unpacker word.
- `ovf_err`  out  1  sticky: a response arrived with no space, or with no request outstanding.

## Operation
- **Reset values:** all outputs are 0, FIFO is empty, unpacker is empty, `trig_q`=0, `discard`=0.
- **Request credit:** `trig_q` is a register holding `gen_trig` from the previous cycle. At most one request is in flight.
  - `gen_trig = !flush && (level + trig_q) < DEPTH`. It is combinational from registers and `flush` only.
  - `gen_trig` is held high continuously while credit exists. A request the generator ignores (busy) simply produces no `gen_ready`, and no bookkeeping is needed.
- **Capture:** on `gen_ready`=1:
  - If `discard`=0 and `trig_q`=1, `gen_num` is pushed to the FIFO.
  - If `trig_q`=0, the word is dropped and `ovf_err` is set.
  - If the FIFO is full, the word is dropped and `ovf_err` is set. The credit rule makes this case unreachable.
  - If `discard`=1, the word is dropped silently.
- **Unpacker:** a 32-bit word register plus slice index `sidx` in 0..K-1.
  - `out_data = word[sidx*OUT_W +: OUT_W]`, least-significant slice first.
  - `out_valid` = unpacker holds a word.
- **Handshake:** a slice transfers when `out_valid && out_ready`.
  - After a transfer, `sidx` increments.
  - On the last slice (`sidx`=K-1), the unpacker reloads from the FIFO head in the same cycle if `level`>0; otherwise it empties and `out_valid` falls.
  - An empty unpacker loads the FIFO head whenever `level`>0.
  - `out_data` is stable while `out_valid && !out_ready`.
- **Simultaneous push and pop:** `level` is unchanged. A push into an empty FIFO while the unpacker is empty takes one cycle to reach the unpacker; there is no bypass.
- **Flush:** in the flush cycle the block empties the FIFO and the unpacker, sets `sidx`=0, forces `gen_trig`=0, and sets `discard <= trig_q`. `discard` clears after one cycle. `ovf_err` is not cleared; only `rst` clears it.
- **Reset mid-operation:** all state clears immediately and asynchronously. A `gen_ready` in the first cycle after deassertion is treated as an error only if it is observed with `trig_q`=0.

## Timing
- Latency from `gen_ready` (push at edge N) to FIFO head at N+1:
  - If the unpacker is empty, the word loads at edge N+1 and `out_valid`=1 from N+1 to N+2.
  - The best-case path from `gen_trig` high to the first `out_valid` is 3 edges.
- Sustained throughput: one word per cycle from the generator, limited by `DEPTH`; one slice per cycle at the output.
- `level` updates on the edge following push or pop.

## Test plan
- **Basic fill:** after reset, a stub generator answers every `gen_trig` next cycle with 0x00000001, 0x00000002, …; `out_ready`=0.
  - `gen_trig` drops once `level`+`trig_q`=4.
  - `level`=4 is held with no `ovf_err`.
  - After `out_ready`=1, words 1, 2, 3, … appear in order, one per cycle.
- **Busy generator:** the stub ignores requests for 20 cycles, then answers.
  - `out_valid` stays 0 with no error, then delivery resumes with no lost or duplicated values.
- **Slicing (`OUT_W`=8):** a single word 0xA1B2C3D4 with `out_ready`=1.
  - `out_data` sequence is 0xD4, 0xC3, 0xB2, 0xA1, then 0x?? of the next word.
  - `out_data` is held under `out_ready` stalls.
- **Flush with request in flight:** assert `flush` in the cycle after `gen_trig`=1.
  - `gen_ready` with 0x55 the next cycle is discarded.
  - `level`=0 and `out_valid`=0; the next delivered word is the following stub value.
- **Protocol error:** the stub pulses `gen_ready` with no preceding `gen_trig`.
  - `ovf_err`=1 and stays set through `flush`; it clears only on `rst`.
- **Asynchronous reset mid-stream:** assert `rst` between edges while `out_valid`=1.
  - `out_valid`, `gen_trig`, `level`, `out_data` and `ovf_err` go to 0 before the next edge.
